// File: rtl/cdc_pkg.sv
// Shared definitions for the four-phase req/ack source-side controller.
//   hs_state_t      : handshake FSM state encoding
//   SYNC_STAGES_MIN : smallest legal synchronizer depth on ack_in
//   QAM_SYMBOL_W    : default transferred word width (one 64-QAM symbol)
package cdc_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        RELEASE = 2'd2
    } hs_state_t;

    localparam int unsigned SYNC_STAGES_MIN = 2;
    localparam int unsigned QAM_SYMBOL_W    = 6;

endpackage

// File: rtl/cdc_sync_bit.sv
// Multi-flop single-bit synchronizer for an asynchronous level input.
//   clk : destination clock
//   rst : asynchronous active-high reset, clears every stage to 0
//   d   : asynchronous input bit
//   q   : synchronized output (last stage)
// STAGES must be at least 2.
module cdc_sync_bit #(
    parameter int unsigned STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] sync;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync <= '0;
        end else begin
            sync <= {sync[STAGES-2:0], d};
        end
    end

    assign q = sync[STAGES-1];

endmodule

// File: rtl/cdc_handshake_ctrl.sv
// Source-side controller for a four-phase req/ack handshake. Takes one word
// on a valid/ready interface, holds it on data_out while req_out is high,
// waits for the synchronized ack, then sequences the return-to-zero phase.
//   clk         : single clock, rising edge
//   rst         : asynchronous active-high reset
//   src_valid   : source word valid
//   src_data    : source word
//   src_ready   : word can be accepted this cycle (combinational)
//   req_out     : registered request to the foreign domain
//   data_out    : registered word, stable while req_out is high
//   ack_in      : asynchronous ack from the foreign domain
//   busy        : high in any state other than IDLE
//   timeout_err : sticky watchdog error
// Optional build macro HS_TIMEOUT_EN adds a TIMEOUT_W-bit watchdog on the
// REQ and RELEASE states; without it timeout_err is constant 0 and the FSM
// waits indefinitely. SYNC_STAGES legal range is 2..4.
module cdc_handshake_ctrl
    import cdc_pkg::*;
#(
    parameter int unsigned DATA_W      = QAM_SYMBOL_W,
    parameter int unsigned SYNC_STAGES = SYNC_STAGES_MIN,
    parameter int unsigned TIMEOUT_W   = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              src_valid,
    input  logic [DATA_W-1:0] src_data,
    output logic              src_ready,
    output logic              req_out,
    output logic [DATA_W-1:0] data_out,
    input  logic              ack_in,
    output logic              busy,
    output logic              timeout_err
);

    hs_state_t         state, state_next;
    logic              req_next;
    logic [DATA_W-1:0] data_next;
    logic              ack_sync;

    cdc_sync_bit #(
        .STAGES (SYNC_STAGES)
    ) u_ack_sync (
        .clk (clk),
        .rst (rst),
        .d   (ack_in),
        .q   (ack_sync)
    );

`ifdef HS_TIMEOUT_EN
    logic [TIMEOUT_W-1:0] wdog;
    logic [TIMEOUT_W-1:0] wdog_inc;
    logic                 wdog_hit;
    logic                 err_q;
    logic                 err_next;

    // Fires on the edge where the count would reach all-ones, so a stalled
    // state lasts exactly 2**TIMEOUT_W - 1 cycles.
    assign wdog_inc = wdog + 1'b1;
    assign wdog_hit = (state != IDLE) && (wdog_inc == '1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wdog  <= '0;
            err_q <= 1'b0;
        end else begin
            err_q <= err_next;
            if (state_next != state) begin
                wdog <= '0;
            end else if (state != IDLE) begin
                wdog <= wdog_inc;
            end
        end
    end

    assign timeout_err = err_q;
`else
    // TIMEOUT_W is always >= 1, so this is constant 0.
    assign timeout_err = (TIMEOUT_W == 0);
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            req_out  <= 1'b0;
            data_out <= '0;
        end else begin
            state    <= state_next;
            req_out  <= req_next;
            data_out <= data_next;
        end
    end

    always_comb begin
        state_next = state;
        req_next   = req_out;
        data_next  = data_out;
        src_ready  = 1'b0;
`ifdef HS_TIMEOUT_EN
        err_next   = err_q;
`endif
        case (state)
            IDLE: begin
                // A stale ack from a previous transfer blocks acceptance.
                src_ready = !ack_sync;
                if (src_valid && !ack_sync) begin
                    data_next  = src_data;
                    req_next   = 1'b1;
                    state_next = REQ;
                end
            end
            REQ: begin
                if (ack_sync) begin
                    req_next   = 1'b0;
                    state_next = RELEASE;
                end
`ifdef HS_TIMEOUT_EN
                else if (wdog_hit) begin
                    req_next   = 1'b0;
                    err_next   = 1'b1;
                    state_next = RELEASE;
                end
`endif
            end
            RELEASE: begin
                if (!ack_sync) begin
                    state_next = IDLE;
                end
`ifdef HS_TIMEOUT_EN
                else if (wdog_hit) begin
                    err_next   = 1'b1;
                    state_next = IDLE;
                end
`endif
            end
            default: begin
                state_next = IDLE;
                req_next   = 1'b0;
            end
        endcase
    end

    assign busy = (state != IDLE);

endmodule

// File: tb/tb_cdc_handshake_ctrl.sv
// Directed bench for cdc_handshake_ctrl: a cycle table for the basic
// transfer, then hand-written sequences for back-to-back words, stale ack,
// asynchronous reset mid-REQ and the watchdog (HS_TIMEOUT_EN) or its absence.
module tb_cdc_handshake_ctrl;

`ifdef HS_TIMEOUT_EN
    localparam int unsigned TW = 4;
`else
    localparam int unsigned TW = 8;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       src_valid = 1'b0;
    logic [5:0] src_data = '0;
    logic       src_ready;
    logic       req_out;
    logic [5:0] data_out;
    logic       ack_in;
    logic       busy;
    logic       timeout_err;

    logic       ack_drv = 1'b0;
    logic       resp_en = 1'b0;
    logic [2:0] req_d   = '0;

    int unsigned n_total = 0;
    int unsigned n_pass  = 0;

    cdc_handshake_ctrl #(
        .DATA_W      (6),
        .SYNC_STAGES (2),
        .TIMEOUT_W   (TW)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .src_valid   (src_valid),
        .src_data    (src_data),
        .src_ready   (src_ready),
        .req_out     (req_out),
        .data_out    (data_out),
        .ack_in      (ack_in),
        .busy        (busy),
        .timeout_err (timeout_err)
    );

    always #5 clk = ~clk;

    // Foreign-side responder: ack follows req three cycles later.
    always @(posedge clk) req_d <= {req_d[1:0], req_out};
    assign ack_in = resp_en ? req_d[2] : ack_drv;

    typedef struct {
        logic       rst;
        logic       valid;
        logic [5:0] data;
        logic       ack;
        logic [9:0] exp;   // {src_ready, req_out, data_out, busy, timeout_err}
    } vec_t;

    vec_t vecs[13];

    function automatic vec_t mk(logic r, logic v, logic [5:0] d, logic a,
                                logic rdy, logic rq, logic [5:0] dat, logic bz);
        vec_t t;
        t.rst = r; t.valid = v; t.data = d; t.ack = a;
        t.exp = {rdy, rq, dat, bz, 1'b0};
        return t;
    endfunction

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle(string name);
        int unsigned n = 0;
        while (busy && n < 100) begin
            tick();
            n++;
        end
        check(name, {31'd0, busy}, 32'd0);
    endtask

    logic [5:0] words[3];
    int unsigned idx;
    int unsigned bad;
    int unsigned cnt;
    logic prev_req, prev_busy;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin
        // 1: reset then single transfer, cycle by cycle
        vecs[0]  = mk(1, 0, 6'h00, 0, 1, 0, 6'h00, 0);
        vecs[1]  = mk(0, 1, 6'h2A, 0, 0, 1, 6'h2A, 1);
        vecs[2]  = mk(0, 1, 6'h3F, 0, 0, 1, 6'h2A, 1);
        vecs[3]  = mk(0, 0, 6'h00, 0, 0, 1, 6'h2A, 1);
        vecs[4]  = mk(0, 0, 6'h00, 1, 0, 1, 6'h2A, 1);
        vecs[5]  = mk(0, 0, 6'h00, 1, 0, 1, 6'h2A, 1);
        vecs[6]  = mk(0, 0, 6'h00, 1, 0, 0, 6'h2A, 1);
        vecs[7]  = mk(0, 0, 6'h00, 1, 0, 0, 6'h2A, 1);
        vecs[8]  = mk(0, 0, 6'h00, 1, 0, 0, 6'h2A, 1);
        vecs[9]  = mk(0, 0, 6'h00, 0, 0, 0, 6'h2A, 1);
        vecs[10] = mk(0, 0, 6'h00, 0, 0, 0, 6'h2A, 1);
        vecs[11] = mk(0, 0, 6'h00, 0, 1, 0, 6'h2A, 0);
        vecs[12] = mk(0, 0, 6'h00, 0, 1, 0, 6'h2A, 0);

        #2;
        for (int i = 0; i < 13; i++) begin
            rst       = vecs[i].rst;
            src_valid = vecs[i].valid;
            src_data  = vecs[i].data;
            ack_drv   = vecs[i].ack;
            tick();
            check($sformatf("vec%0d", i),
                  {22'd0, src_ready, req_out, data_out, busy, timeout_err},
                  {22'd0, vecs[i].exp});
        end

        // 2: back-to-back words with src_valid held
        words[0] = 6'h01; words[1] = 6'h3F; words[2] = 6'h15;
        resp_en = 1'b1;
        idx = 0; bad = 0;
        src_valid = 1'b1;
        src_data  = words[0];
        prev_req  = req_out;
        prev_busy = busy;
        for (int c = 0; c < 200 && idx < 3; c++) begin
            tick();
            if (req_out && !prev_req) begin
                check($sformatf("b2b_from_idle%0d", idx), {31'd0, prev_busy}, 32'd0);
                check($sformatf("b2b_data%0d", idx), {26'd0, data_out}, {26'd0, words[idx]});
                idx++;
                if (idx < 3) src_data = words[idx];
                else src_valid = 1'b0;
            end else if (req_out && data_out != words[idx-1]) begin
                bad++;
            end
            prev_req  = req_out;
            prev_busy = busy;
        end
        check("b2b_count", idx, 3);
        check("b2b_hold", bad, 0);
        wait_idle("b2b_idle");
        resp_en = 1'b0;

        // 3: stale ack blocks acceptance until it clears through the sync
        ack_drv = 1'b1;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        repeat (3) tick();
        src_valid = 1'b1;
        src_data  = 6'h07;
        bad = 0;
        repeat (4) begin
            tick();
            if (src_ready || req_out || busy) bad++;
        end
        check("stale_hold", bad, 0);
        ack_drv = 1'b0;
        tick();
        check("stale_e1", {30'd0, src_ready, req_out}, {30'd0, 2'b00});
        tick();
        check("stale_e2", {30'd0, src_ready, req_out}, {30'd0, 2'b10});
        tick();
        check("stale_accept", {25'd0, req_out, data_out}, {25'd0, 1'b1, 6'h07});
        src_valid = 1'b0;

        // 4: asynchronous reset while in REQ
        rst = 1'b1;
        tick();
        rst = 1'b0;
        src_valid = 1'b1;
        src_data  = 6'h0C;
        tick();
        check("rst_pre", {25'd0, req_out, data_out}, {25'd0, 1'b1, 6'h0C});
        src_valid = 1'b0;
        tick();
        #2;
        rst = 1'b1;
        #1;
        check("rst_async", {24'd0, req_out, data_out, busy}, 32'd0);
        tick();
        rst = 1'b0;
        resp_en = 1'b1;
        src_valid = 1'b1;
        src_data  = 6'h33;
        cnt = 0;
        while (!req_out && cnt < 20) begin
            tick();
            cnt++;
        end
        src_valid = 1'b0;
        check("rst_resume", {25'd0, req_out, data_out}, {25'd0, 1'b1, 6'h33});
        wait_idle("rst_resume_idle");
        resp_en = 1'b0;
        ack_drv = 1'b0;
        repeat (4) tick();

        // 5/6: ack never arrives
        rst = 1'b1;
        tick();
        rst = 1'b0;
        src_valid = 1'b1;
        src_data  = 6'h2D;
        tick();
        src_valid = 1'b0;
        check("noack_req", {31'd0, req_out}, 32'd1);
`ifdef HS_TIMEOUT_EN
        cnt = 1;
        for (int c = 0; c < 100 && req_out; c++) begin
            tick();
            if (req_out) cnt++;
        end
        check("to_req_cycles", cnt, 15);
        check("to_err_set", {31'd0, timeout_err}, 32'd1);
        tick();
        check("to_idle", {29'd0, src_ready, busy, timeout_err}, {29'd0, 3'b101});
        repeat (5) tick();
        check("to_sticky", {31'd0, timeout_err}, 32'd1);
`else
        bad = 0;
        repeat (1000) begin
            tick();
            if (!req_out || timeout_err || !busy) bad++;
        end
        check("noto_wait", bad, 0);
        check("noto_err", {31'd0, timeout_err}, 32'd0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
